pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
Registered, parametrised successor to the combinational RV32IM decoder. It decodes the instruction in ID and holds the control bundle in an ID/EX pipeline register. It supports stall and flush from the hazard unit and gates issue while a multi-cycle M-extension operation occupies EX. It sits between the IF/ID register and the EX stage.

Parameters:
MULDIV_CYCLES, 4, EX occupancy in cycles of any M-extension op (funct7=0000001); legal range 1..15; 1 means no extra busy cycles.
ENABLE_M, 1, when 0 every M-extension encoding decodes as illegal.
ALUOP_W, 5, width of alu_opcode.

Ports:
clk  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
instruction  in  32  instruction from IF/ID
in_valid  in  1  instruction slot holds a real instruction
stall_in  in  1  hazard unit holds ID/EX
flush  in  1  branch/jump redirect; kill ID/EX contents
in_ready  out  1  ID/EX accepts a new entry this cycle
out_valid  out  1  ID/EX entry is a real instruction
write_enable  out  1  register writeback
memory_access  out  1  load/store
mem_read  out  1  load
mem_write  out  1  store
jump_and_link  out  1  JAL/JALR
branch  out  1  B-type
jump  out  1  JAL/JALR
imm_sel  out  3  I=000, S=001, J=010, U=011, B=100
immediate_select  out  2  operand-B source, 10=immediate, 00=register
offset_generator  out  2  PC-offset source, 10=PC-relative, 00=none
alu_opcode  out  ALUOP_W  ALU operation
funct3_out  out  3  funct3 passthrough (branch condition / memory size)
rd_out  out  5  destination register
md_op  out  1  entry is an M-extension op
md_busy  out  1  M-extension op still occupying EX
illegal  out  1  entry is an illegal/unsupported encoding

Behaviour:
- Reset (async, reset_n=0): every output and the internal counter are 0, except in_ready, which follows its combinational equation and reads 0 while md_cnt=0 only if stall_in=1. Deassertion is synchronised to the clk edge.
- in_ready = !stall_in && (md_cnt==0), combinational.
- ID/EX update priority at each rising edge:
  1. flush: out_valid<=0, all control outputs<=0, md_cnt<=0.
  2. !in_ready: hold every output.
  3. in_valid=1: load the decoded bundle, out_valid<=1.
  4. in_valid=0: load a bubble (all zeros).
- Latency: 1 cycle from accepted instruction to outputs.
- Flush overrides both stall and busy in the same cycle.
- md_cnt (4 bits):
  - Loaded with MULDIV_CYCLES-1 when an md_op entry is loaded.
  - Otherwise decrements while nonzero.
  - md_busy = (md_cnt!=0), driven from the register.
  - With MULDIV_CYCLES=1 the counter never leaves 0.
  - stall_in does not freeze the count.
- alu_opcode encodings: ADD 00000, SUB 00001, OR 00010, XOR 00011, AND 00100, SRL 00101, SLL 00110, SRA 00111, MUL 01000, MULH 01001, MULHSU 01010 (f3=010), MULHU 01011 (f3=011), DIV 01100, DIVU 01101, REM 01110, REMU 01111, SLT 10000, LUI-pass 10001, SLTU 10010.
- R-type (0110011): decode on {funct7,funct3}. SLTU is f3=011 with funct7=0. OP-IMM (0010011) includes SLTIU=10010. Shift-immediate funct7 must be 0000000 or, for SRAI only, 0100000; anything else is illegal.
- Load/Store/JAL/JALR/LUI/AUIPC/Branch: control values as the existing decoder, with alu_opcode=ADD except LUI=10001.
- Illegal decode:
  - Triggers: unknown opcode, unknown funct combination, or M op with ENABLE_M=0.
  - Outputs: illegal=1, out_valid=1, all write/memory/branch/jump controls 0, alu_opcode=0, md_op=0.
- Decode is purely a function of instruction. No X values are ever driven; unspecified fields are 0.

Test Plan:
- Reset asserted mid-busy (DIV loaded, md_cnt=2) -> all outputs 0 immediately (asynchronous, before the next edge); after release the first instruction is accepted the next cycle.
- instruction=0x002081B3 (add x3,x1,x2), in_valid=1 -> next cycle out_valid=1, alu_opcode=00000, write_enable=1, rd_out=3, illegal=0.
- MULDIV_CYCLES=4, instruction=0x0220C1B3 (div x3,x1,x2) -> alu_opcode=01100, md_op=1, md_busy=1 and in_ready=0 for exactly 3 cycles, outputs held; the next add is loaded on the 4th edge.
- stall_in=1 for 2 cycles with a new instruction on the input -> outputs unchanged; the instruction loads on the edge after stall_in falls.
- flush=1 together with stall_in=1 while busy -> next cycle out_valid=0, md_busy=0, write_enable=0.
- instruction=0x0000007F -> illegal=1, write_enable=0. With ENABLE_M=0, instruction=0x022081B3 (mul) -> illegal=1, md_busy stays 0.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// RV32IM decode stage with a registered ID/EX control bundle.
// Supports stall, flush and issue gating while a multi-cycle mul/div occupies EX.
module pipelined_control_unit #(
  parameter int MULDIV_CYCLES = 4,
  parameter bit ENABLE_M      = 1'b1,
  parameter int ALUOP_W       = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        instruction,
  input  logic               in_valid,
  input  logic               stall_in,
  input  logic               flush,
  output logic               in_ready,
  output logic               out_valid,
  output logic               write_enable,
  output logic               memory_access,
  output logic               mem_read,
  output logic               mem_write,
  output logic               jump_and_link,
  output logic               branch,
  output logic               jump,
  output logic [2:0]         imm_sel,
  output logic [1:0]         immediate_select,
  output logic [1:0]         offset_generator,
  output logic [ALUOP_W-1:0] alu_opcode,
  output logic [2:0]         funct3_out,
  output logic [4:0]         rd_out,
  output logic               md_op,
  output logic               md_busy,
  output logic               illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_J = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_B = 3'b100;

  localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 1);

  typedef struct packed {
    logic               write_enable;
    logic               memory_access;
    logic               mem_read;
    logic               mem_write;
    logic               jump_and_link;
    logic               branch;
    logic               jump;
    logic [2:0]         imm_sel;
    logic [1:0]         immediate_select;
    logic [1:0]         offset_generator;
    logic [ALUOP_W-1:0] alu_opcode;
    logic [2:0]         funct3;
    logic [4:0]         rd;
    logic               md_op;
    logic               illegal;
  } ctrl_t;

  function automatic logic [ALUOP_W-1:0] aop(input logic [4:0] code);
    return ALUOP_W'(code);
  endfunction

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       bad;
  logic       unused_bits;
  ctrl_t      dec;
  ctrl_t      ctrl_d, ctrl_q;
  logic       out_valid_d, out_valid_q;
  logic [3:0] md_cnt_d, md_cnt_q;

  assign opcode      = instruction[6:0];
  assign f3          = instruction[14:12];
  assign f7          = instruction[31:25];
  assign unused_bits = ^instruction[24:15];

  always_comb begin
    dec = '0;
    bad = 1'b0;
    case (opcode)
      OP_R: begin
        dec.write_enable = 1'b1;
        dec.funct3       = f3;
        dec.rd           = instruction[11:7];
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000:  dec.alu_opcode = aop(5'b00000);
              3'b001:  dec.alu_opcode = aop(5'b00110);
              3'b010:  dec.alu_opcode = aop(5'b10000);
              3'b011:  dec.alu_opcode = aop(5'b10010);
              3'b100:  dec.alu_opcode = aop(5'b00011);
              3'b101:  dec.alu_opcode = aop(5'b00101);
              3'b110:  dec.alu_opcode = aop(5'b00010);
              default: dec.alu_opcode = aop(5'b00100);
            endcase
          end
          7'b0100000: begin
            if (f3 == 3'b000)      dec.alu_opcode = aop(5'b00001);
            else if (f3 == 3'b101) dec.alu_opcode = aop(5'b00111);
            else                   bad = 1'b1;
          end
          7'b0000001: begin
            if (ENABLE_M) begin
              dec.alu_opcode = aop({2'b01, f3});
              dec.md_op      = 1'b1;
            end else begin
              bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      OP_IMM: begin
        dec.write_enable     = 1'b1;
        dec.imm_sel          = IMM_I;
        dec.immediate_select = 2'b10;
        dec.funct3           = f3;
        dec.rd               = instruction[11:7];
        case (f3)
          3'b000: dec.alu_opcode = aop(5'b00000);
          3'b010: dec.alu_opcode = aop(5'b10000);
          3'b011: dec.alu_opcode = aop(5'b10010);
          3'b100: dec.alu_opcode = aop(5'b00011);
          3'b110: dec.alu_opcode = aop(5'b00010);
          3'b111: dec.alu_opcode = aop(5'b00100);
          3'b001: begin
            if (f7 == 7'b0000000) dec.alu_opcode = aop(5'b00110);
            else                  bad = 1'b1;
          end
          default: begin
            if (f7 == 7'b0000000)      dec.alu_opcode = aop(5'b00101);
            else if (f7 == 7'b0100000) dec.alu_opcode = aop(5'b00111);
            else                       bad = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        dec.write_enable     = 1'b1;
        dec.memory_access    = 1'b1;
        dec.mem_read         = 1'b1;
        dec.imm_sel          = IMM_I;
        dec.immediate_select = 2'b10;
        dec.funct3           = f3;
        dec.rd               = instruction[11:7];
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        dec.memory_access    = 1'b1;
        dec.mem_write        = 1'b1;
        dec.imm_sel          = IMM_S;
        dec.immediate_select = 2'b10;
        dec.funct3           = f3;
        bad = f3[2] || (f3 == 3'b011);
      end
      OP_BRANCH: begin
        dec.branch           = 1'b1;
        dec.imm_sel          = IMM_B;
        dec.offset_generator = 2'b10;
        dec.funct3           = f3;
        bad = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_JAL: begin
        dec.write_enable     = 1'b1;
        dec.jump_and_link    = 1'b1;
        dec.jump             = 1'b1;
        dec.imm_sel          = IMM_J;
        dec.immediate_select = 2'b10;
        dec.offset_generator = 2'b10;
        dec.rd               = instruction[11:7];
      end
      OP_JALR: begin
        dec.write_enable     = 1'b1;
        dec.jump_and_link    = 1'b1;
        dec.jump             = 1'b1;
        dec.imm_sel          = IMM_I;
        dec.immediate_select = 2'b10;
        dec.funct3           = f3;
        dec.rd               = instruction[11:7];
        bad = (f3 != 3'b000);
      end
      OP_LUI: begin
        dec.write_enable     = 1'b1;
        dec.imm_sel          = IMM_U;
        dec.immediate_select = 2'b10;
        dec.alu_opcode       = aop(5'b10001);
        dec.rd               = instruction[11:7];
      end
      OP_AUIPC: begin
        dec.write_enable     = 1'b1;
        dec.imm_sel          = IMM_U;
        dec.immediate_select = 2'b10;
        dec.offset_generator = 2'b10;
        dec.rd               = instruction[11:7];
      end
      default: bad = 1'b1;
    endcase
    // Illegal entries carry nothing but the flag itself.
    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign in_ready = !stall_in && (md_cnt_q == 4'd0);

  always_comb begin
    ctrl_d      = ctrl_q;
    out_valid_d = out_valid_q;
    md_cnt_d    = (md_cnt_q != 4'd0) ? md_cnt_q - 4'd1 : 4'd0;
    if (flush) begin
      ctrl_d      = '0;
      out_valid_d = 1'b0;
      md_cnt_d    = 4'd0;
    end else if (in_ready) begin
      if (in_valid) begin
        ctrl_d      = dec;
        out_valid_d = 1'b1;
        if (dec.md_op) md_cnt_d = MD_LOAD;
      end else begin
        ctrl_d      = '0;
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q      <= '0;
      out_valid_q <= 1'b0;
      md_cnt_q    <= 4'd0;
    end else begin
      ctrl_q      <= ctrl_d;
      out_valid_q <= out_valid_d;
      md_cnt_q    <= md_cnt_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign write_enable     = ctrl_q.write_enable;
  assign memory_access    = ctrl_q.memory_access;
  assign mem_read         = ctrl_q.mem_read;
  assign mem_write        = ctrl_q.mem_write;
  assign jump_and_link    = ctrl_q.jump_and_link;
  assign branch           = ctrl_q.branch;
  assign jump             = ctrl_q.jump;
  assign imm_sel          = ctrl_q.imm_sel;
  assign immediate_select = ctrl_q.immediate_select;
  assign offset_generator = ctrl_q.offset_generator;
  assign alu_opcode       = ctrl_q.alu_opcode;
  assign funct3_out       = ctrl_q.funct3;
  assign rd_out           = ctrl_q.rd;
  assign md_op            = ctrl_q.md_op;
  assign illegal          = ctrl_q.illegal;
  assign md_busy          = (md_cnt_q != 4'd0);

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: one default instance and one with
// the M extension disabled, both fed the same stimulus.
module tb_pipelined_control_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instruction;
  logic        in_valid, stall_in, flush;

  logic       in_ready, out_valid, write_enable, memory_access, mem_read, mem_write;
  logic       jump_and_link, branch, jump, md_op, md_busy, illegal;
  logic [2:0] imm_sel, funct3_out;
  logic [1:0] immediate_select, offset_generator;
  logic [4:0] alu_opcode, rd_out;

  logic       nm_in_ready, nm_out_valid, nm_write_enable, nm_memory_access, nm_mem_read;
  logic       nm_mem_write, nm_jump_and_link, nm_branch, nm_jump, nm_md_op, nm_md_busy;
  logic       nm_illegal;
  logic [2:0] nm_imm_sel, nm_funct3_out;
  logic [1:0] nm_immediate_select, nm_offset_generator;
  logic [4:0] nm_alu_opcode, nm_rd_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_control_unit #(.MULDIV_CYCLES(4), .ENABLE_M(1'b1), .ALUOP_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .in_valid(in_valid),
    .stall_in(stall_in), .flush(flush), .in_ready(in_ready), .out_valid(out_valid),
    .write_enable(write_enable), .memory_access(memory_access), .mem_read(mem_read),
    .mem_write(mem_write), .jump_and_link(jump_and_link), .branch(branch), .jump(jump),
    .imm_sel(imm_sel), .immediate_select(immediate_select),
    .offset_generator(offset_generator), .alu_opcode(alu_opcode),
    .funct3_out(funct3_out), .rd_out(rd_out), .md_op(md_op), .md_busy(md_busy),
    .illegal(illegal)
  );

  pipelined_control_unit #(.MULDIV_CYCLES(4), .ENABLE_M(1'b0), .ALUOP_W(5)) dut_nm (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .in_valid(in_valid),
    .stall_in(stall_in), .flush(flush), .in_ready(nm_in_ready), .out_valid(nm_out_valid),
    .write_enable(nm_write_enable), .memory_access(nm_memory_access),
    .mem_read(nm_mem_read), .mem_write(nm_mem_write), .jump_and_link(nm_jump_and_link),
    .branch(nm_branch), .jump(nm_jump), .imm_sel(nm_imm_sel),
    .immediate_select(nm_immediate_select), .offset_generator(nm_offset_generator),
    .alu_opcode(nm_alu_opcode), .funct3_out(nm_funct3_out), .rd_out(nm_rd_out),
    .md_op(nm_md_op), .md_busy(nm_md_busy), .illegal(nm_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_DIV   = 32'h0220C1B3;
  localparam logic [31:0] I_SUB   = 32'h407302B3;
  localparam logic [31:0] I_MUL   = 32'h022081B3;
  localparam logic [31:0] I_BAD   = 32'h0000007F;
  localparam logic [31:0] I_SRAI  = 32'h40315093;
  localparam logic [31:0] I_SLLIX = 32'h40311093;
  localparam logic [31:0] I_LW    = 32'h00812203;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_LUI   = 32'h123452B7;

  initial begin
    reset_n = 1'b0; instruction = 32'h0; in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_alu", alu_opcode, 0);
    chk("rst_in_ready", in_ready, 1);
    stall_in = 1'b1;
    #1;
    chk("rst_in_ready_stall", in_ready, 0);
    stall_in = 1'b0;

    @(negedge clk);
    reset_n = 1'b1;
    instruction = I_ADD; in_valid = 1'b1;
    step();
    chk("add_valid", out_valid, 1);
    chk("add_alu", alu_opcode, 5'b00000);
    chk("add_we", write_enable, 1);
    chk("add_rd", rd_out, 3);
    chk("add_illegal", illegal, 0);

    // Divide: three busy cycles with outputs held, next add on the fourth edge.
    instruction = I_DIV;
    step();
    chk("div_alu", alu_opcode, 5'b01100);
    chk("div_md_op", md_op, 1);
    chk("div_busy0", md_busy, 1);
    chk("div_ready0", in_ready, 0);
    instruction = I_ADD;
    for (int i = 1; i < 3; i++) begin
      step();
      chk("div_busy_n", md_busy, 1);
      chk("div_ready_n", in_ready, 0);
      chk("div_hold_alu", alu_opcode, 5'b01100);
    end
    step();
    chk("div_busy_end", md_busy, 0);
    chk("div_ready_end", in_ready, 1);
    chk("div_hold_last", alu_opcode, 5'b01100);
    step();
    chk("after_div_alu", alu_opcode, 5'b00000);
    chk("after_div_md_op", md_op, 0);

    // Stall for two edges with sub waiting.
    instruction = I_SUB; stall_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_hold_alu", alu_opcode, 5'b00000);
      chk("stall_hold_rd", rd_out, 3);
    end
    stall_in = 1'b0;
    step();
    chk("sub_alu", alu_opcode, 5'b00001);
    chk("sub_rd", rd_out, 5);

    // Flush together with stall while busy.
    instruction = I_DIV;
    step();
    chk("div2_busy", md_busy, 1);
    flush = 1'b1; stall_in = 1'b1;
    step();
    chk("flush_valid", out_valid, 0);
    chk("flush_busy", md_busy, 0);
    chk("flush_we", write_enable, 0);
    chk("flush_alu", alu_opcode, 0);
    flush = 1'b0; stall_in = 1'b0;

    in_valid = 1'b0;
    step();
    chk("bubble_valid", out_valid, 0);
    chk("bubble_we", write_enable, 0);

    in_valid = 1'b1; instruction = I_BAD;
    step();
    chk("bad_illegal", illegal, 1);
    chk("bad_valid", out_valid, 1);
    chk("bad_we", write_enable, 0);

    instruction = I_SRAI;
    step();
    chk("srai_alu", alu_opcode, 5'b00111);
    chk("srai_isel", immediate_select, 2'b10);
    chk("srai_illegal", illegal, 0);

    instruction = I_SLLIX;
    step();
    chk("slli_f7_illegal", illegal, 1);
    chk("slli_f7_alu", alu_opcode, 0);

    instruction = I_LW;
    step();
    chk("lw_mem_read", mem_read, 1);
    chk("lw_mem_access", memory_access, 1);
    chk("lw_we", write_enable, 1);
    chk("lw_f3", funct3_out, 3'b010);
    chk("lw_rd", rd_out, 4);

    instruction = I_SW;
    step();
    chk("sw_mem_write", mem_write, 1);
    chk("sw_we", write_enable, 0);
    chk("sw_imm_sel", imm_sel, 3'b001);

    instruction = I_LUI;
    step();
    chk("lui_alu", alu_opcode, 5'b10001);
    chk("lui_imm_sel", imm_sel, 3'b011);
    chk("lui_rd", rd_out, 5);

    // Mul: legal on the default instance, illegal with M disabled.
    instruction = I_MUL;
    step();
    chk("mul_alu", alu_opcode, 5'b01000);
    chk("mul_busy", md_busy, 1);
    chk("nm_mul_illegal", nm_illegal, 1);
    chk("nm_mul_valid", nm_out_valid, 1);
    chk("nm_mul_we", nm_write_enable, 0);
    chk("nm_mul_md_op", nm_md_op, 0);
    chk("nm_mul_busy", nm_md_busy, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nm_busy_stays0", nm_md_busy, 0);
      chk("nm_ready", nm_in_ready, 1);
    end
    chk("mul_drained", in_ready, 1);

    // Reset asserted mid-busy: outputs clear without waiting for an edge.
    in_valid = 1'b1; instruction = I_DIV;
    step();
    step();
    chk("pre_rst_busy", md_busy, 1);
    reset_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_busy", md_busy, 0);
    chk("async_alu", alu_opcode, 0);
    chk("async_md_op", md_op, 0);
    chk("async_we", write_enable, 0);
    @(negedge clk);
    reset_n = 1'b1;
    instruction = I_ADD;
    step();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_alu", alu_opcode, 5'b00000);
    chk("post_rst_busy", md_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
